// File: rtl/serial_queue_link.sv
// serial_queue_link
// Single-clock serial receive front end: clock-enable tick generators, a
// WIDTH-bit MSB-first deserializer and a DEPTH-entry FIFO, joined by a word
// handshake so a completed word is held until the queue can accept it.
//
// Parameters
//   WIDTH    bits per word (>=2)
//   DEPTH    FIFO entries (power of two, >=2)
//   DES_DIV  clocks per deserializer tick (>=1)
//   FIFO_DIV clocks per queue tick (>=1)
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-high
//   data_in         serial bit, sampled on deserializer ticks
//   write_in        qualifies data_in on deserializer ticks
//   dequeue_in      dequeue request level, sampled on queue ticks
//   status_out      deserializer holds a complete, not yet queued word
//   data_out        last dequeued word (registered)
//   data_valid_out  one-clock pulse when data_out is loaded
//   len_out         FIFO occupancy 0..DEPTH
//   full_out        len_out == DEPTH
//   empty_out       len_out == 0
//   drop_out        sticky: a bit was offered while the deserializer was busy
module serial_queue_link #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int DES_DIV  = 10,
  parameter int FIFO_DIV = 100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic                       status_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       drop_out
);

  localparam int DCW = (DES_DIV  > 1) ? $clog2(DES_DIV)  : 1;
  localparam int FCW = (FIFO_DIV > 1) ? $clog2(FIFO_DIV) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int BW  = $clog2(WIDTH);

  localparam logic [DCW-1:0] DES_LAST  = DCW'(DES_DIV - 1);
  localparam logic [FCW-1:0] FIFO_LAST = FCW'(FIFO_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [LW-1:0]  LEN_FULL  = LW'(DEPTH);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } des_state_t;

  // Tick generators
  logic [DCW-1:0] des_cnt_q, des_cnt_d;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic           des_tick, fifo_tick;

  // Deserializer
  des_state_t     state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           drop_q, drop_d;

  // FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  len_q, len_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic           valid_q;
  logic           full, empty, enq, deq;

  assign des_tick  = (des_cnt_q  == DES_LAST);
  assign fifo_tick = (fifo_cnt_q == FIFO_LAST);

  always_comb begin
    des_cnt_d  = des_tick  ? '0 : des_cnt_q  + DCW'(1);
    fifo_cnt_d = fifo_tick ? '0 : fifo_cnt_q + FCW'(1);
  end

  assign full  = (len_q == LEN_FULL);
  assign empty = (len_q == '0);

  // No bypass: a dequeue on an empty queue does nothing even if a word is
  // being pushed on the same edge. A full queue still accepts a push when a
  // pop frees a slot on that edge.
  assign deq = fifo_tick & dequeue_in & ~empty;
  assign enq = fifo_tick & (state_q == HOLD) & (~full | deq);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    drop_d    = drop_q;
    unique case (state_q)
      COLLECT: begin
        if (des_tick && write_in) begin
          shift_d = {shift_q[WIDTH-2:0], data_in};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      HOLD: begin
        // Still HOLD on the enqueue edge, so a bit arriving then is dropped too.
        if (des_tick && write_in) drop_d = 1'b1;
        if (enq) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    data_d   = deq ? mem_q[rd_ptr_q] : data_q;
    len_d    = len_q;
    unique case ({enq, deq})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      des_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      state_q    <= COLLECT;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      des_cnt_q  <= des_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      valid_q    <= deq;
    end
  end

  // Storage is not reset: stale entries are unreachable once the pointers
  // and occupancy are cleared, and data_out itself is reset.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= shift_q;
  end

  assign status_out     = (state_q == HOLD);
  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign len_out        = len_q;
  assign full_out       = full;
  assign empty_out      = empty;
  assign drop_out       = drop_q;

endmodule

// File: tb/tb_serial_queue_link.sv
module tb_serial_queue_link;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int DES_DIV  = 2;
  localparam int FIFO_DIV = 4;

  logic             clock;
  logic             reset;
  logic             data_in;
  logic             write_in;
  logic             dequeue_in;
  logic             status_out;
  logic [WIDTH-1:0] data_out;
  logic             data_valid_out;
  logic [2:0]       len_out;
  logic             full_out;
  logic             empty_out;
  logic             drop_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;           // rising edges since reset released
  int exp_q[$];            // expected FIFO contents
  int held_word = -1;      // word waiting in the deserializer, -1 if none

  serial_queue_link #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .DES_DIV (DES_DIV),
    .FIFO_DIV(FIFO_DIV)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .write_in      (write_in),
    .dequeue_in    (dequeue_in),
    .status_out    (status_out),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .len_out       (len_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .drop_out      (drop_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // des_tick on edges where cyc is even, fifo_tick where cyc % 4 == 0
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait until the next fifo_tick edge is four edges away.
  task automatic align4();
    for (int k = 0; k < 4 && (cyc % 4) != 0; k++) @(negedge clock);
  endtask

  // Present one bit for DES_DIV edges: exactly one des_tick samples it.
  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    repeat (2) @(negedge clock);
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    align4();
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    check("status_before_last_bit", 32'(status_out), 0);
    send_bit(w[0]);
    // last bit sampled on a fifo_tick edge while still COLLECT
    check("status_rise", 32'(status_out), 1);
    repeat (4) @(negedge clock);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(int'(w));
      check("status_after_enq", 32'(status_out), 0);
      check("len_after_enq", 32'(len_out), 32'(exp_q.size()));
    end else begin
      held_word = int'(w);
      check("status_held_full", 32'(status_out), 1);
      check("full_held", 32'(full_out), 1);
      check("len_held", 32'(len_out), DEPTH);
    end
  endtask

  task automatic deq_word();
    int expw;
    expw = exp_q.pop_front();
    if (held_word >= 0) begin
      exp_q.push_back(held_word);
      held_word = -1;
    end
    align4();
    dequeue_in = 1'b1;
    repeat (4) @(negedge clock);
    dequeue_in = 1'b0;
    check("deq_valid", 32'(data_valid_out), 1);
    check("deq_data", 32'(data_out), 32'(expw));
    check("deq_len", 32'(len_out), 32'(exp_q.size()));
    @(negedge clock);
    check("deq_valid_drop", 32'(data_valid_out), 0);
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 1'b0;
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_status", 32'(status_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid_out), 0);
    check("rst_len", 32'(len_out), 0);
    check("rst_full", 32'(full_out), 0);
    check("rst_empty", 32'(empty_out), 1);
    check("rst_drop", 32'(drop_out), 0);
    reset = 1'b0;

    // Single word
    send_word(8'hA5);
    deq_word();
    check("single_empty", 32'(empty_out), 1);

    // Fill to full, hold the fifth, drop a bit, pop with simultaneous push
    for (int i = 1; i <= 5; i++) send_word(8'(i));
    check("fill_drop_before", 32'(drop_out), 0);
    send_bit(1'b1);
    check("fill_drop_set", 32'(drop_out), 1);
    check("fill_still_held", 32'(status_out), 1);
    deq_word();
    check("fill_len_stays", 32'(len_out), 4);
    check("fill_status_clear", 32'(status_out), 0);
    for (int i = 0; i < 4; i++) deq_word();
    check("fill_drained_empty", 32'(empty_out), 1);

    // Wrap-around: alternate push and pop
    for (int i = 0; i < 10; i++) begin
      send_word(8'(8'h10 + i));
      deq_word();
    end

    // Dequeue while empty
    dequeue_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("empty_deq_no_valid", 32'(data_valid_out), 0);
    end
    dequeue_in = 1'b0;
    check("empty_deq_data_hold", 32'(data_out), 32'h19);
    check("empty_deq_len", 32'(len_out), 0);
    check("empty_deq_empty", 32'(empty_out), 1);

    // Word ready and dequeue on the same fifo_tick with an empty FIFO
    align4();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h6E >> i));
    check("simul_status", 32'(status_out), 1);
    dequeue_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("simul_no_valid", 32'(data_valid_out), 0);
    end
    dequeue_in = 1'b0;
    check("simul_len", 32'(len_out), 1);
    check("simul_status_clear", 32'(status_out), 0);
    check("simul_not_empty", 32'(empty_out), 0);

    // Reset mid-word (drop_out is still set, len_out is 1)
    align4();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    #1;
    check("midrst_status", 32'(status_out), 0);
    check("midrst_data", 32'(data_out), 0);
    check("midrst_valid", 32'(data_valid_out), 0);
    check("midrst_len", 32'(len_out), 0);
    check("midrst_full", 32'(full_out), 0);
    check("midrst_empty", 32'(empty_out), 1);
    check("midrst_drop", 32'(drop_out), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    held_word = -1;
    send_word(8'h3C);
    deq_word();
    check("post_rst_empty", 32'(empty_out), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_queue_link.md
# serial_queue_link

Parametrised single-clock serial-to-parallel front end for the serial receive path. It combines tick generators, a WIDTH-bit deserializer, and a DEPTH-entry FIFO in one block. The divided-clock scheme is replaced by clock enables. The free-running toggled acknowledge is replaced by a defined word handshake between deserializer and queue, so no bits or words are lost silently.

## Interface
- WIDTH, 8: bits per word; must be ≥2.
- DEPTH, 8: FIFO entries; must be a power of two, ≥2.
- DES_DIV, 10: clocks per deserializer tick; must be ≥1 (1 = every clock).
- FIFO_DIV, 100: clocks per queue tick; must be ≥1.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_in  in  1  serial bit, sampled MSB-first on deserializer ticks.
- write_in  in  1  qualifies data_in on deserializer ticks.
- dequeue_in  in  1  level; sampled on queue ticks.
- status_out  out  1  deserializer holds a complete word that is not yet queued (busy).
- data_out  out  WIDTH  last dequeued word (registered).
- data_valid_out  out  1  one-clock pulse on the edge where data_out is loaded.
- len_out  out  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- full_out / empty_out  out  1  len_out==DEPTH / len_out==0.
- drop_out  out  1  sticky; set when a serial bit is offered while the deserializer is busy.

## Operation
- **Tick generators:**
  - Two counters: des_cnt counts 0..DES_DIV-1 and fifo_cnt counts 0..FIFO_DIV-1. Each wraps to 0.
  - des_tick = (des_cnt==DES_DIV-1) and fifo_tick = (fifo_cnt==FIFO_DIV-1), both combinational.
  - All deserializer and FIFO actions occur only on edges where the respective tick is high.
- **Deserializer FSM, states COLLECT and HOLD:**
  - COLLECT, on an edge with des_tick & write_in: shift data_in into the LSB of the shift register (first bit ends up as MSB) and increment bit_cnt.
    - When the WIDTH-th bit is taken, go to HOLD and clear bit_cnt.
  - COLLECT, on an edge with des_tick & !write_in: nothing. A partial word is retained indefinitely.
  - HOLD: status_out=1. Shift register frozen.
    - An edge with des_tick & write_in sets drop_out; the bit is discarded.
  - HOLD -> COLLECT on the edge where the FIFO accepts the word. Serial sampling resumes from the next des_tick.
- **FIFO, on each fifo_tick edge:**
  - enq = HOLD & (!full | deq).
  - deq = dequeue_in & !empty.
  - On enq: mem[wr_ptr] <= shift register, and wr_ptr wraps modulo DEPTH.
  - On deq: data_out <= mem[rd_ptr], rd_ptr wraps, and data_valid_out=1 for this single clock.
  - Occupancy update: len += enq - deq.
    - Both enq and deq: len is unchanged.
    - Full with both: the push is allowed because the read frees a slot.
    - Empty with both: only the push happens; deq=0 (no bypass).
  - Dequeue when empty: ignored; data_out holds and no valid pulse is produced.
  - HOLD while full and without deq: the word waits; status_out stays 1.
- **Reset (asynchronous):** clears counters, pointers, bit_cnt, shift register, and memory contents' read path; FSM goes to COLLECT.
  - Output values: status_out=0, data_out=0, data_valid_out=0, len_out=0, full_out=0, empty_out=1, drop_out=0.
  - A partial word or held word at reset is discarded.

## Timing
- First des_tick edge is the DES_DIV-th rising edge after reset deasserts; likewise FIFO_DIV for fifo_tick.
- status_out rises on the edge that samples the last bit.
- The word is enqueued at the first subsequent fifo_tick edge at which enq holds. status_out falls and len_out increments on that same edge.
- If des_tick coincides with the enqueue edge: the FSM is still HOLD on that edge, so the bit is dropped (drop_out set if write_in).
- Minimum word-to-queue latency: WIDTH des_ticks plus up to FIFO_DIV clocks.
- full_out, empty_out, and len_out change only on fifo_tick edges or reset.
- data_valid_out is high exactly one clock, the cycle after the dequeuing edge, and coincides with the new data_out.

## Test plan
- **Single word.** WIDTH=8, DEPTH=4, DES_DIV=2, FIFO_DIV=4. Shift 0xA5 MSB-first, then pulse dequeue_in.
  - status_out rises after the 8th tick, then len_out=1 and status_out=0.
  - After dequeue: data_out=0xA5, data_valid_out pulses once, empty_out=1.
- **Fill to full.** Send 5 words 0x01..0x05 with no dequeue.
  - len_out=4 and full_out=1; status_out stays 1 holding 0x05.
  - Further bits set drop_out=1.
  - One dequeue returns 0x01, and 0x05 is enqueued on the same edge; len_out stays 4.
- **Wrap-around.** Push and pop 10 words alternately; data_out returns them in order with the pointer wrap intact.
- **Empty dequeue.** Hold dequeue_in=1 with an empty FIFO: data_out unchanged, no data_valid_out, len_out=0.
- **Simultaneous on empty.** Word ready and dequeue_in=1 on the same fifo_tick with an empty FIFO: len_out becomes 1 and no data_valid_out.
- **Reset mid-word.** Assert reset after 3 bits: all outputs take their reset values immediately. A following full 0x3C is received intact.
